task_sequencer: RTL and testbench
=================================

Name: task_sequencer

Overview:
Top-level scheduler for task_manager. It walks the enabled-task mask from task 1 upward and drives current_task_number for each enabled task in turn. For each task it resets the task_manager datapath, pulses start_tests, then waits for tasks_done or a watchdog timeout. It records per-task pass/timeout status and cycle counts for the host register file. It sits between the AXI-Lite control registers and task_manager.

Parameters:
NUMBER_OF_TASKS, 16, number of task slots scanned (1..32); must match task_manager.
TM_RST_CYCLES, 4, cycles o_tm_rst is held high before each task start (>=1).
TIMEOUT_CYCLES, 32'd1_000_000, watchdog limit per task in cycles; 0 disables the watchdog.

Ports:
i_clk  in  1  system clock.
i_rst  in  1  synchronous active-high reset.
i_start  in  1  level; sampled only in IDLE; begins a run.
i_abort  in  1  level; terminates a run from any non-IDLE state.
i_enabled_tasks  in  32  enable mask from task_manager; bit k-1 enables task k; bits >= NUMBER_OF_TASKS are ignored.
i_tasks_done  in  1  task_manager done flag (sticky until task_manager reset).
o_tm_rst  out  1  task_manager datapath reset, OR'd externally with i_rst.
o_start_tests  out  1  one-cycle start pulse to task_manager.
o_current_task_number  out  32  task index to task_manager; 0 means no task granted.
o_busy  out  1  high from leaving IDLE until FINISH is entered.
o_done  out  1  one-cycle pulse at end of run.
o_aborted  out  1  sticky; set by abort; cleared at next run start.
o_pass_mask  out  32  bit k-1 is set when task k reports done.
o_timeout_mask  out  32  bit k-1 is set when task k times out.
o_task_cycles  out  32  cycles from start pulse to done/timeout for the most recently finished task; saturates at 32'hFFFF_FFFF.

Behaviour:
- Reset: state=IDLE. All outputs are 0. Internal idx=0 and watchdog=0.
- States: IDLE, SCAN, TM_RESET, START, WAIT, NEXT, FINISH.
- IDLE: if i_start=1, clear o_pass_mask, o_timeout_mask, o_aborted and o_task_cycles; set idx=1; go to SCAN.
- SCAN, one index per cycle:
  - If i_enabled_tasks[idx-1]=1: load o_current_task_number=idx and go to TM_RESET.
  - Otherwise, if idx==NUMBER_OF_TASKS, go to FINISH; else idx+=1.
  - A mask with no enabled bits reaches FINISH after NUMBER_OF_TASKS SCAN cycles.
- TM_RESET: o_tm_rst=1 for exactly TM_RST_CYCLES cycles, then go to START.
- START: o_start_tests=1 for exactly one cycle; watchdog=0; go to WAIT.
- WAIT: watchdog increments every cycle, saturating.
  - If i_tasks_done=1: set o_pass_mask[idx-1]; o_task_cycles=watchdog+1; go to NEXT.
  - Else, if TIMEOUT_CYCLES!=0 and watchdog==TIMEOUT_CYCLES-1: set o_timeout_mask[idx-1]; o_task_cycles=TIMEOUT_CYCLES; go to NEXT.
  - If done and timeout occur in the same cycle, done wins: the task counts as a pass.
- NEXT: o_current_task_number=0 and o_tm_rst=1 for this one cycle. If idx==NUMBER_OF_TASKS go to FINISH; else idx+=1 and go to SCAN.
- FINISH: o_done=1 for one cycle, o_busy=0, o_current_task_number=0; go to IDLE.
- Abort: i_abort=1 in any state other than IDLE or FINISH means the next state is FINISH.
  - o_aborted is set.
  - The current task's mask bits are left unchanged.
  - o_start_tests is forced to 0 that cycle.
  - i_abort in IDLE is ignored.
- i_start while busy is ignored. i_start held high across FINISH starts a new run on the next IDLE cycle.
- i_rst mid-run returns to IDLE next cycle with all outputs cleared. No o_done pulse is generated.
- i_enabled_tasks is re-sampled on each SCAN cycle. Mask changes mid-run affect only tasks not yet scanned.
- Latency, idle to first start: IDLE(start seen) -> SCAN -> TM_RESET x TM_RST_CYCLES -> START. With task 1 enabled and TM_RST_CYCLES=4, o_start_tests rises 6 cycles after the cycle i_start is sampled.

Test Plan:
- Single task: mask=0x1, done asserted 10 cycles after start pulse -> o_pass_mask=0x1, o_task_cycles=10, o_timeout_mask=0, one o_done pulse; o_start_tests high for exactly 1 cycle.
- Multi task: mask=0x0000_0237 -> o_current_task_number sequence is 1,2,3,5,6,10; exactly 6 start pulses; o_tm_rst high for 4 cycles before each start; final o_pass_mask=0x237.
- Timeout: TIMEOUT_CYCLES=50, mask=0x5, task 1 never done, task 3 done at cycle 20 -> o_timeout_mask=0x1, o_pass_mask=0x4, o_task_cycles=20.
- Tie: done asserted in exactly the timeout cycle (watchdog==TIMEOUT_CYCLES-1) -> pass bit set, timeout bit clear.
- Abort/reset: i_abort during WAIT of task 2 (mask=0x7) -> o_done pulse next cycle, o_aborted=1, o_pass_mask=0x1, task 3 never started. i_rst in WAIT -> all outputs 0, no o_done pulse.
- Empty mask: mask=0x0 -> no o_tm_rst and no start pulses; o_done pulses NUMBER_OF_TASKS+1 cycles after start is sampled; masks stay 0.

Source files
------------

// File: rtl/task_sequencer.sv
// ============================================================================
// task_sequencer: walks the enabled-task mask, resets/starts each task_manager
// run, guards it with a watchdog and records pass/timeout status and cycles.
// Revision: 1.0
// ============================================================================
`default_nettype none

module task_sequencer #(
  parameter int unsigned NUMBER_OF_TASKS = 16,
  parameter int unsigned TM_RST_CYCLES   = 4,
  parameter logic [31:0] TIMEOUT_CYCLES  = 32'd1_000_000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [31:0] i_enabled_tasks,
  input  logic        i_tasks_done,
  output logic        o_tm_rst,
  output logic        o_start_tests,
  output logic [31:0] o_current_task_number,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_aborted,
  output logic [31:0] o_pass_mask,
  output logic [31:0] o_timeout_mask,
  output logic [31:0] o_task_cycles
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SCAN     = 3'd1;
  localparam logic [2:0] S_TM_RESET = 3'd2;
  localparam logic [2:0] S_START    = 3'd3;
  localparam logic [2:0] S_WAIT     = 3'd4;
  localparam logic [2:0] S_NEXT     = 3'd5;
  localparam logic [2:0] S_FINISH   = 3'd6;

  localparam logic [5:0]  C_LAST_IDX = 6'(NUMBER_OF_TASKS);
  localparam logic [31:0] C_RST_LAST = 32'(TM_RST_CYCLES - 1);
  localparam logic [31:0] C_TMO_LAST = TIMEOUT_CYCLES - 32'd1;
  localparam logic        C_TMO_EN   = (TIMEOUT_CYCLES != 32'd0);

  logic [2:0]  state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [31:0] rst_cnt_q, rst_cnt_d;
  logic [31:0] wdog_q, wdog_d;
  logic [31:0] pass_q, pass_d;
  logic [31:0] tmo_q, tmo_d;
  logic [31:0] cycles_q, cycles_d;
  logic        aborted_q, aborted_d;

  logic [4:0]  w_pos;
  logic [31:0] w_bit;
  logic        w_en;
  logic        w_last;
  logic        w_abort;
  logic [31:0] w_wdog_inc;

  // idx runs 1..32; the low five bits minus one give the mask position (32 -> 31).
  assign w_pos      = idx_q[4:0] - 5'd1;
  assign w_bit      = 32'd1 << w_pos;
  assign w_en       = i_enabled_tasks[w_pos];
  assign w_last     = (idx_q == C_LAST_IDX);
  assign w_abort    = i_abort && (state_q != S_IDLE) && (state_q != S_FINISH);
  assign w_wdog_inc = (wdog_q == 32'hFFFF_FFFF) ? wdog_q : wdog_q + 32'd1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      idx_q     <= 6'd0;
      rst_cnt_q <= 32'd0;
      wdog_q    <= 32'd0;
      pass_q    <= 32'd0;
      tmo_q     <= 32'd0;
      cycles_q  <= 32'd0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rst_cnt_q <= rst_cnt_d;
      wdog_q    <= wdog_d;
      pass_q    <= pass_d;
      tmo_q     <= tmo_d;
      cycles_q  <= cycles_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rst_cnt_d = rst_cnt_q;
    wdog_d    = wdog_q;
    pass_d    = pass_q;
    tmo_d     = tmo_q;
    cycles_d  = cycles_q;
    aborted_d = aborted_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          pass_d    = 32'd0;
          tmo_d     = 32'd0;
          cycles_d  = 32'd0;
          aborted_d = 1'b0;
          idx_d     = 6'd1;
          state_d   = S_SCAN;
        end
      end
      S_SCAN: begin
        if (w_en) begin
          rst_cnt_d = 32'd0;
          state_d   = S_TM_RESET;
        end else if (w_last) begin
          state_d = S_FINISH;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      S_TM_RESET: begin
        if (rst_cnt_q == C_RST_LAST) state_d = S_START;
        else                         rst_cnt_d = rst_cnt_q + 32'd1;
      end
      S_START: begin
        wdog_d  = 32'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wdog_d = w_wdog_inc;
        // done is checked first so a tie with the watchdog limit counts as a pass
        if (i_tasks_done) begin
          pass_d   = pass_q | w_bit;
          cycles_d = w_wdog_inc;
          state_d  = S_NEXT;
        end else if (C_TMO_EN && (wdog_q == C_TMO_LAST)) begin
          tmo_d    = tmo_q | w_bit;
          cycles_d = TIMEOUT_CYCLES;
          state_d  = S_NEXT;
        end
      end
      S_NEXT: begin
        if (w_last) begin
          state_d = S_FINISH;
        end else begin
          idx_d   = idx_q + 6'd1;
          state_d = S_SCAN;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (w_abort) begin
      state_d   = S_FINISH;
      aborted_d = 1'b1;
      pass_d    = pass_q;
      tmo_d     = tmo_q;
      cycles_d  = cycles_q;
    end
  end

  always_comb begin
    o_tm_rst              = 1'b0;
    o_start_tests         = 1'b0;
    o_current_task_number = 32'd0;
    o_busy                = 1'b0;
    o_done                = 1'b0;
    o_aborted             = aborted_q;
    o_pass_mask           = pass_q;
    o_timeout_mask        = tmo_q;
    o_task_cycles         = cycles_q;
    case (state_q)
      S_SCAN:     o_busy = 1'b1;
      S_TM_RESET: begin
        o_busy                = 1'b1;
        o_tm_rst              = 1'b1;
        o_current_task_number = {26'd0, idx_q};
      end
      S_START: begin
        o_busy                = 1'b1;
        o_start_tests         = ~i_abort;
        o_current_task_number = {26'd0, idx_q};
      end
      S_WAIT: begin
        o_busy                = 1'b1;
        o_current_task_number = {26'd0, idx_q};
      end
      S_NEXT: begin
        o_busy   = 1'b1;
        o_tm_rst = 1'b1;
      end
      S_FINISH: o_done = 1'b1;
      default:  o_done = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_task_sequencer.sv
// ============================================================================
// tb_task_sequencer: directed and randomized runs against a cycle-count model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_task_sequencer;

  localparam int N   = 16;
  localparam int TMR = 4;
  localparam int TMO = 50;

  logic        clk = 1'b0;
  logic        rst, start, abort, done_in;
  logic [31:0] en;
  logic        o_tm_rst, o_start_tests, o_busy, o_done, o_aborted;
  logic [31:0] o_cur, o_pass, o_tmo, o_cyc;

  task_sequencer #(
    .NUMBER_OF_TASKS(N),
    .TM_RST_CYCLES  (TMR),
    .TIMEOUT_CYCLES (32'd50)
  ) dut (
    .i_clk                (clk),
    .i_rst                (rst),
    .i_start              (start),
    .i_abort              (abort),
    .i_enabled_tasks      (en),
    .i_tasks_done         (done_in),
    .o_tm_rst             (o_tm_rst),
    .o_start_tests        (o_start_tests),
    .o_current_task_number(o_cur),
    .o_busy               (o_busy),
    .o_done               (o_done),
    .o_aborted            (o_aborted),
    .o_pass_mask          (o_pass),
    .o_timeout_mask       (o_tmo),
    .o_task_cycles        (o_cyc)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int dly[1:32];  // done latency after the start pulse; 0 = never

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_tm_rst"}, {31'd0, o_tm_rst}, 32'd0);
    chk({tag, "_start"}, {31'd0, o_start_tests}, 32'd0);
    chk({tag, "_cur"}, o_cur, 32'd0);
    chk({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, o_done}, 32'd0);
    chk({tag, "_aborted"}, {31'd0, o_aborted}, 32'd0);
    chk({tag, "_pass"}, o_pass, 32'd0);
    chk({tag, "_tmo"}, o_tmo, 32'd0);
    chk({tag, "_cycles"}, o_cyc, 32'd0);
  endtask

  // One run; ab_task != 0 raises abort on WAIT cycle ab_j of that task.
  task automatic run(input logic [31:0] mask, input int ab_task, input int ab_j);
    int t, fin, cyc, run_len, cur, j, done_at, n;
    int exp_list[$];
    int got_list[$];
    logic [31:0] e_pass, e_tmo, e_cyc;
    bit e_ab, armed;
    t = 0; e_pass = 0; e_tmo = 0; e_cyc = 0; e_ab = 0; fin = 0;
    for (int k = 1; k <= N; k++) begin
      t++;
      if (mask[k-1]) begin
        t += TMR + 1;
        exp_list.push_back(k);
        if (k == ab_task) begin
          fin  = t + ab_j + 1;
          e_ab = 1;
          break;
        end
        if (dly[k] != 0 && dly[k] <= TMO) begin
          e_pass[k-1] = 1'b1; e_cyc = dly[k]; t += dly[k];
        end else begin
          e_tmo[k-1] = 1'b1; e_cyc = TMO; t += TMO;
        end
        t++;
      end
    end
    if (!e_ab) fin = t + 1;

    @(negedge clk);
    en = mask; start = 1'b1;
    cyc = 0; run_len = 0; armed = 0; cur = 0; j = 0; done_at = -1;
    while (cyc < 5000 && done_at < 0) begin
      @(negedge clk);
      cyc++; start = 1'b0; abort = 1'b0;
      if (o_tm_rst) begin done_in = 1'b0; armed = 0; end
      if (o_start_tests) begin
        chk("tm_rst_len", run_len, TMR);
        chk("busy_run", {31'd0, o_busy}, 32'd1);
        got_list.push_back(int'(o_cur));
        cur = int'(o_cur); j = 0; armed = 1;
      end else if (armed) begin
        j++;
        if (cur == ab_task && j == ab_j) abort = 1'b1;
        if (cur >= 1 && cur <= 32 && dly[cur] != 0 && j == dly[cur]) done_in = 1'b1;
      end
      run_len = o_tm_rst ? run_len + 1 : 0;
      if (o_done) done_at = cyc;
    end
    chk("done_cycle", done_at, fin);
    chk("pass_mask", o_pass, e_pass);
    chk("timeout_mask", o_tmo, e_tmo);
    chk("task_cycles", o_cyc, e_cyc);
    chk("aborted", {31'd0, o_aborted}, {31'd0, e_ab});
    chk("busy_finish", {31'd0, o_busy}, 32'd0);
    chk("n_starts", got_list.size(), exp_list.size());
    n = (got_list.size() < exp_list.size()) ? got_list.size() : exp_list.size();
    for (int i = 0; i < n; i++) chk("task_seq", got_list[i], exp_list[i]);
    @(negedge clk);
    abort = 1'b0; done_in = 1'b0;
    chk("done_width", {31'd0, o_done}, 32'd0);
    chk("pass_hold", o_pass, e_pass);
  endtask

  task automatic clear_dly();
    for (int k = 1; k <= 32; k++) dly[k] = 0;
  endtask

  initial begin
    int wait_cnt;
    logic [31:0] m;
    rst = 1'b1; start = 1'b0; abort = 1'b0; done_in = 1'b0; en = 32'd0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    clear_dly(); dly[1] = 10;
    run(32'h1, 0, 0);

    clear_dly();
    foreach (dly[k]) dly[k] = int'($urandom_range(1, 40));
    run(32'h0000_0237, 0, 0);

    clear_dly(); dly[3] = 20;
    run(32'h5, 0, 0);

    clear_dly(); dly[1] = TMO;
    run(32'h1, 0, 0);
    clear_dly(); dly[2] = TMO + 1;
    run(32'h2, 0, 0);

    clear_dly(); dly[1] = 5; dly[2] = 40; dly[3] = 7;
    run(32'h7, 2, 5);

    run(32'h0, 0, 0);
    run(32'hFFFF_0000, 0, 0);

    clear_dly(); dly[16] = 3;
    run(32'h8000_8000, 0, 0);

    for (int r = 0; r < 8; r++) begin
      for (int k = 1; k <= 32; k++) begin
        case ($urandom_range(0, 9))
          0:       dly[k] = 0;
          1:       dly[k] = TMO;
          default: dly[k] = int'($urandom_range(1, 60));
        endcase
      end
      m = $urandom;
      run(m, 0, 0);
    end

    // synchronous reset in the middle of a WAIT
    clear_dly();
    @(negedge clk);
    en = 32'h7; start = 1'b1;
    wait_cnt = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      wait_cnt++;
    end while (!o_start_tests && wait_cnt < 100);
    chk("rst_test_started", {31'd0, o_start_tests}, 32'd1);
    repeat (3) @(negedge clk);
    chk("rst_test_busy", {31'd0, o_busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("midrun_rst");
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_done", {31'd0, o_done}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
